// File: rtl/leb128_pkg.sv
// Shared constants for the LEB128 immediate decoder: FSM encoding, trap codes, length limits.
// Build option LEB128_STRICT_EN (see leb128_final_check) enables the unused-bit range trap.
package leb128_pkg;

  localparam int MAX_BYTES_32 = 5;
  localparam int MAX_BYTES_64 = 10;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  localparam logic [3:0] TRAP_NONE     = 4'd0;
  localparam logic [3:0] TRAP_OVERLONG = 4'd1;
  localparam logic [3:0] TRAP_RANGE    = 4'd2;

endpackage

// File: rtl/leb128_final_check.sv
// Combinational checks on the terminating byte: sign-extension mask and unused-bit range error.
// With LEB128_STRICT_EN undefined the range error is tied low and excess bits are simply dropped.
module leb128_final_check
  import leb128_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [6:0]            payload,
  input  logic [6:0]            shift,
  input  logic                  is_64,
  input  logic                  is_signed,
  output logic [DATA_WIDTH-1:0] ext_mask,
  output logic                  range_err
);

  logic [6:0]            shift_next;
  logic [DATA_WIDTH-1:0] mode_mask;

  assign shift_next = shift + 7'd7;
  assign mode_mask  = is_64 ? {DATA_WIDTH{1'b1}}
                            : {{(DATA_WIDTH-32){1'b0}}, 32'hFFFF_FFFF};

  // Shifts of 64 or more yield zero, so nothing is extended past the top.
  assign ext_mask = (is_signed && payload[6]) ? (({DATA_WIDTH{1'b1}} << shift_next) & mode_mask)
                                              : '0;

`ifdef LEB128_STRICT_EN
  logic [7:0] width;
  logic       sign_bit;

  // Payload bit i lands at result bit shift+i; anything at or above the mode width is unused.
  always_comb begin
    width     = is_64 ? 8'(DATA_WIDTH) : 8'd32;
    sign_bit  = 1'b0;
    range_err = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (({1'b0, shift} + 8'(i)) == (width - 8'd1)) sign_bit = payload[i];
    end
    for (int i = 0; i < 7; i++) begin
      if ((({1'b0, shift} + 8'(i)) >= width) && (payload[i] != (is_signed & sign_bit)))
        range_err = 1'b1;
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/leb128_decoder.sv
// Streaming LEB128 immediate decoder (signed/unsigned, 32/64-bit runtime mode) with overlong trap.
// Build option LEB128_STRICT_EN adds the trap=2 unused-bit range check on max-length encodings.
module leb128_decoder
  import leb128_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic                  is_64,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic [3:0]            trap,
  output logic [1:0]            state_dbg
);

  // Handshake: a byte moves when byte_valid && byte_ready in the same cycle; a result moves when
  // result_valid && result_ready. Neither valid may depend on its ready; both hold until taken.

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [6:0]            shift;
  logic [3:0]            count;
  logic                  mode_64;
  logic                  mode_signed;
  logic [DATA_WIDTH-1:0] result_q;
  logic [3:0]            trap_q;

  logic                  accept;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [3:0]            count_next;
  logic [3:0]            max_bytes;
  logic                  at_max;
  logic [DATA_WIDTH-1:0] ext_mask;
  logic                  range_err;
  logic [DATA_WIDTH-1:0] final_value;

  assign byte_ready   = (state == ST_DECODE);
  assign result_valid = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);
  assign result       = result_q;
  assign trap         = trap_q;
  assign state_dbg    = state;

  assign accept     = byte_valid && byte_ready;
  assign acc_next   = acc | (DATA_WIDTH'(byte_in[6:0]) << shift);
  assign count_next = count + 4'd1;
  assign max_bytes  = mode_64 ? 4'(MAX_BYTES_64) : 4'(MAX_BYTES_32);
  assign at_max     = (count_next == max_bytes);

  leb128_final_check #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_final_check (
    .payload   (byte_in[6:0]),
    .shift     (shift),
    .is_64     (mode_64),
    .is_signed (mode_signed),
    .ext_mask  (ext_mask),
    .range_err (range_err)
  );

  // 32-bit mode keeps the upper word clear even when the last byte spills past bit 31.
  always_comb begin
    final_value = acc_next | ext_mask;
    if (!mode_64) final_value[DATA_WIDTH-1:32] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      acc         <= '0;
      shift       <= '0;
      count       <= '0;
      mode_64     <= 1'b0;
      mode_signed <= 1'b0;
      result_q    <= '0;
      trap_q      <= TRAP_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            mode_64     <= is_64;
            mode_signed <= is_signed;
            acc         <= '0;
            shift       <= '0;
            count       <= '0;
            trap_q      <= TRAP_NONE;
            state       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (accept) begin
            acc   <= acc_next;
            shift <= shift + 7'd7;
            count <= count_next;
            if (!byte_in[7]) begin
              if (at_max && range_err) begin
                trap_q <= TRAP_RANGE;
                state  <= ST_ERROR;
              end else begin
                result_q <= final_value;
                state    <= ST_DONE;
              end
            end else if (at_max) begin
              trap_q <= TRAP_OVERLONG;
              state  <= ST_ERROR;
            end
          end
        end
        ST_DONE: begin
          if (result_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leb128_decoder.sv
// Self-checking bench for leb128_decoder: directed cases plus randomized encodings against an
// arithmetic reference model. Honors LEB128_STRICT_EN the same way the design does.
module tb_leb128_decoder;
  import leb128_pkg::*;

`ifdef LEB128_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic        is_64;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [63:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic [3:0]  trap;
  logic [1:0]  state_dbg;

  int          n_checks = 0;
  int          n_fail = 0;
  int          busy_cnt = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stim_q[$];

  leb128_decoder #(.DATA_WIDTH(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .is_64        (is_64),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .trap         (trap),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(negedge clk) if (busy) busy_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: value = sum(payload_i * 128^i), minus 128^n when signed and the last byte's bit 6
  // is set; the range check asks whether that exact value fits the target integer type.
  function automatic void ref_decode(input bit sgn, input bit w64,
                                     output logic [63:0] val, output logic [3:0] tcode);
    int                 w;
    int                 n;
    logic signed [127:0] v;
    logic signed [127:0] lim;
    logic [7:0]          last;
    w     = w64 ? 64 : 32;
    n     = stim_q.size();
    v     = '0;
    val   = '0;
    tcode = TRAP_NONE;
    for (int i = 0; i < n; i++) v = v + (128'(stim_q[i][6:0]) << (7 * i));
    last = stim_q[n-1];
    if (last[7]) begin
      tcode = TRAP_OVERLONG;
      return;
    end
    if (sgn && last[6]) v = v - (128'sd1 <<< (7 * n));
    lim = 128'sd1 <<< (w - 1);
    if (STRICT && n == (w64 ? MAX_BYTES_64 : MAX_BYTES_32)) begin
      if (sgn ? ((v >= lim) || (v < -lim)) : (v >= (lim <<< 1))) begin
        tcode = TRAP_RANGE;
        return;
      end
    end
    val = v[63:0];
    if (!w64) val[63:32] = '0;
  endfunction

  // ---------------- driver ----------------
  task automatic run_decode(input bit sgn, input bit w64, input int hold, input bit noise,
                            output logic [3:0] exp_trap);
    logic [63:0] exp_val;
    logic [63:0] got;
    int          t;
    ref_decode(sgn, w64, exp_val, exp_trap);
    if (exp_trap == TRAP_NONE) exp_q.push_back(exp_val);

    start = 1'b1; is_signed = sgn; is_64 = w64;
    @(posedge clk); #1;
    start = 1'b0;
    if (noise) begin
      is_signed = 1'($urandom);
      is_64     = 1'($urandom);
    end
    check("start_trap_clear", 64'(trap), 64'(TRAP_NONE));
    check("decode_ready", 64'(byte_ready), 64'd1);

    for (int i = 0; i < stim_q.size(); i++) begin
      if (noise) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        repeat ($urandom_range(0, 2)) begin
          start = 1'($urandom);
          @(posedge clk); #1;
        end
        start = 1'b0;
      end
      byte_in    = stim_q[i];
      byte_valid = 1'b1;
      t = 0;
      while (!byte_ready && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      check("byte_ready_wait", 64'(byte_ready), 64'd1);
      @(posedge clk); #1;
      byte_valid = 1'b0;
    end

    if (exp_trap == TRAP_NONE) begin
      check("latency_valid", 64'(result_valid), 64'd1);
      check("trap_none", 64'(trap), 64'(TRAP_NONE));
      result_ready = 1'b0;
      for (int c = 0; c < hold; c++) begin
        if (noise) begin
          byte_valid = 1'b1;
          byte_in    = 8'($urandom);
          start      = 1'($urandom);
        end
        @(posedge clk); #1;
        check("hold_valid", 64'(result_valid), 64'd1);
        check("hold_result", result, exp_q[0]);
      end
      start      = 1'b0;
      byte_valid = 1'b0;
      got        = result;
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      check("result", got, exp_q.pop_front());
      check("idle_after_take", 64'(busy), 64'd0);
      check("valid_drop", 64'(result_valid), 64'd0);
    end else begin
      check("trap_code", 64'(trap), 64'(exp_trap));
      check("error_ready", 64'(byte_ready), 64'd0);
      check("error_valid", 64'(result_valid), 64'd0);
      check("error_state", 64'(state_dbg), 64'(ST_ERROR));
      @(posedge clk); #1;
      check("trap_held", 64'(trap), 64'(exp_trap));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] et;
    int         base;
    bit         sgn;
    bit         w64;
    int         mx;
    int         n;
    logic [7:0] b;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; is_64 = 1'b0;
    byte_in = '0; byte_valid = 1'b0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_trap", 64'(trap), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    reset = 1'b0;
    @(posedge clk); #1;

    // i32 signed 42
    stim_q.delete(); stim_q.push_back(8'h2A);
    run_decode(1'b1, 1'b0, 0, 1'b0, et);
    check("i32_42", result, 64'd42);

    // i32 signed -1
    stim_q.delete(); stim_q.push_back(8'h7F);
    run_decode(1'b1, 1'b0, 0, 1'b0, et);
    check("i32_minus1", result, 64'h0000_0000_FFFF_FFFF);

    // u32 624485, zero-wait stream
    stim_q.delete(); stim_q.push_back(8'hE5); stim_q.push_back(8'h8E); stim_q.push_back(8'h26);
    base = busy_cnt;
    run_decode(1'b0, 1'b0, 0, 1'b0, et);
    check("u32_624485", result, 64'd624485);
    check("busy_cycles", 64'(busy_cnt - base), 64'd4);

    // i64 -123456 with backpressure
    stim_q.delete(); stim_q.push_back(8'hC0); stim_q.push_back(8'hBB); stim_q.push_back(8'h78);
    run_decode(1'b1, 1'b1, 5, 1'b0, et);
    check("i64_minus123456", result, 64'hFFFF_FFFF_FFFE_1DC0);

    // i32 overlong
    stim_q.delete();
    repeat (5) stim_q.push_back(8'h80);
    run_decode(1'b1, 1'b0, 0, 1'b0, et);
    check("overlong_trap", 64'(trap), 64'(TRAP_OVERLONG));

    // u32 with a set unused bit in the fifth byte
    stim_q.delete();
    repeat (4) stim_q.push_back(8'hFF);
    stim_q.push_back(8'h1F);
    run_decode(1'b0, 1'b0, 0, 1'b0, et);
`ifdef LEB128_STRICT_EN
    check("u32_range_trap", 64'(trap), 64'(TRAP_RANGE));
`else
    check("u32_truncate", result, 64'h0000_0000_FFFF_FFFF);
`endif

    // i32 INT_MIN at max length (legal)
    stim_q.delete();
    repeat (4) stim_q.push_back(8'h80);
    stim_q.push_back(8'h78);
    run_decode(1'b1, 1'b0, 1, 1'b0, et);
    check("i32_min", result, 64'h0000_0000_8000_0000);

    // u64 all ones at max length (legal)
    stim_q.delete();
    repeat (9) stim_q.push_back(8'hFF);
    stim_q.push_back(8'h01);
    run_decode(1'b0, 1'b1, 0, 1'b0, et);
    check("u64_max", result, 64'hFFFF_FFFF_FFFF_FFFF);

    // Randomized encodings with gaps, stray start/byte_valid and backpressure
    for (int k = 0; k < 250; k++) begin
      sgn = 1'($urandom);
      w64 = 1'($urandom);
      mx  = w64 ? MAX_BYTES_64 : MAX_BYTES_32;
      stim_q.delete();
      if ($urandom_range(0, 9) == 0) begin
        for (int i = 0; i < mx; i++) stim_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
      end else begin
        n = $urandom_range(1, mx);
        for (int i = 0; i < n; i++) begin
          b = 8'($urandom_range(0, 127));
          if (i < n - 1) b = b | 8'h80;
          stim_q.push_back(b);
        end
      end
      run_decode(sgn, w64, $urandom_range(0, 3), 1'b1, et);
      if (et == TRAP_NONE) begin
        byte_valid = 1'b1;
        byte_in    = 8'($urandom);
        @(posedge clk); #1;
        byte_valid = 1'b0;
        check("idle_no_consume", 64'(busy), 64'd0);
      end
    end

    // Asynchronous reset in the middle of a decode
    start = 1'b1; is_signed = 1'b0; is_64 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    byte_valid = 1'b1; byte_in = 8'h85;
    @(posedge clk); #1;
    byte_in = 8'h81;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(byte_ready), 64'd0);
    check("mid_rst_valid", 64'(result_valid), 64'd0);
    check("mid_rst_trap", 64'(trap), 64'd0);
    check("mid_rst_result", result, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(state_dbg), 64'(ST_IDLE));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leb128_decoder.md
Name: leb128_decoder

Overview:
- Streaming LEB128 immediate decoder for the wasm cpu fetch path. It turns the variable-length encodings behind i32.const/i64.const (and unsigned indices) into a fixed-width result word.
- Generalises the fixed i32 immediate path: runtime 32/64-bit mode, signed or unsigned, and overlong/range traps.
- Sits between the ROM byte fetcher and the operand-stack push logic.

Parameters:
- DATA_WIDTH, 64, result width; must be 64 (32-bit mode is a runtime option).
- MAX_BYTES_32, 5, maximum encoded length in 32-bit mode, ceil(32/7).
- MAX_BYTES_64, 10, maximum encoded length in 64-bit mode, ceil(64/7).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin decode; samples is_signed and is_64
- is_signed  in  1  1 = sLEB128, 0 = uLEB128
- is_64  in  1  1 = 64-bit target, 0 = 32-bit target
- byte_in  in  8  encoded byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  decoder accepts byte this cycle
- result  out  64  decoded value
- result_valid  out  1  result available
- result_ready  in  1  consumer takes result
- busy  out  1  decoder is not IDLE
- trap  out  4  0 none, 1 overlong, 2 unused-bit range error

Behaviour:
- Reset is asynchronous, active-high (clk/reset as elsewhere in the cpu). On reset: state IDLE, result=0, result_valid=0, byte_ready=0, busy=0, trap=0, shift=0, count=0.
- States and transitions:
  - IDLE: on start, latch mode, clear acc/shift/count/trap, go to DECODE.
  - DECODE: byte_ready=1. A byte is accepted when byte_valid&&byte_ready. On accept: acc |= byte_in[6:0]<<shift, shift+=7, count+=1.
    - byte_in[7]=0 -> go to DONE.
    - byte_in[7]=1 and count reaches the mode max -> go to ERROR, trap=1.
  - DONE: result_valid=1, result stable. On result_ready go to IDLE; result_valid drops the next cycle.
  - ERROR: trap held, byte_ready=0, result_valid never asserts. start clears trap and begins a new decode.
- busy=1 in DECODE, DONE and ERROR.
- Latency: result_valid rises exactly 1 cycle after the final byte is accepted.
- Width rules:
  - Signed: if the final byte has bit6=1, sign-extend from bit (shift+7) up to the mode width.
  - 32-bit mode: result[63:32]=0 in all cases; the signed value lives in [31:0].
  - Bits above the mode width from the last byte are discarded (subject to the strict check below).
- Boundaries:
  - start outside IDLE/ERROR is ignored.
  - byte_valid in IDLE/DONE is not consumed.
  - A byte accepted with count at max-1 and bit7=0 is legal.
  - Zero-wait streaming: one byte per cycle.
  - Reset mid-decode aborts immediately; no result, no trap.
  - Backpressure: result and result_valid hold indefinitely while result_ready=0.

Optional Feature:
- Macro LEB128_STRICT_EN.
- Defined: the final byte at max length must carry only valid upper bits.
  - Unsigned: unused bits must be 0.
  - Signed: unused bits must equal the sign bit.
  - Violation -> ERROR with trap=2, no result.
- Undefined: unused bits are silently truncated, trap=2 is never produced, and the decode completes normally.

Decomposition:
- Package leb128_pkg holds:
  - state enum IDLE/DECODE/DONE/ERROR;
  - trap codes TRAP_NONE=0, TRAP_OVERLONG=1, TRAP_RANGE=2;
  - constants MAX_BYTES_32 and MAX_BYTES_64.
- One natural sub-module: leb128_final_check, combinational. Given the last byte, shift, mode and sign, it produces the sign-extension mask and the range-error flag.

Test Plan:
- i32 signed, start then byte 0x2A -> result=42 one cycle after accept, result_valid=1, trap=0.
- i32 signed, byte 0x7F -> result=0x00000000FFFFFFFF (-1 in [31:0]).
- Unsigned i32, bytes 0xE5 0x8E 0x26 back-to-back -> result=624485 (0x98765), busy=1 for 4 cycles.
- i64 signed, bytes 0xC0 0xBB 0x78 -> result=0xFFFFFFFFFFFE1DC0 (-123456); hold result_ready=0 for 5 cycles -> result stable, then handshake returns to IDLE.
- i32, five bytes 0x80 -> trap=1 after 5th accept, byte_ready=0, no result_valid; a subsequent start clears trap.
- Unsigned i32, bytes 0xFF 0xFF 0xFF 0xFF 0x1F:
  - With LEB128_STRICT_EN -> trap=2.
  - Without -> result=0x00000000FFFFFFFF, trap=0.
- Reset asserted mid-decode (after 2 bytes) -> outputs return to reset values immediately, without waiting for a clock edge.
